// File: rtl/dm_pkg.sv
// Shared data-memory definitions: MemByte size encoding, load FSM states, alignment rule.
package dm_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } ld_state_e;

  // 2'b01 is an alias for word, so anything not half/byte checks full word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_BYTE: return 1'b0;
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_unit_if.sv
// Request, memory read port and response signals of the load unit.
interface dm_load_unit_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;

    modport slave (
        input  req_valid, req_addr, req_size, req_unsigned, mem_rdata, resp_ready,
        output req_ready, mem_rd, mem_addr, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_addr, req_size, req_unsigned, mem_rdata, resp_ready,
        input  req_ready, mem_rd, mem_addr, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/load_align.sv
// Little-endian sub-word extraction with sign/zero extension for a 32-bit memory word.
module load_align
    import dm_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[7:0];
        case (addr_lo_i)
            2'b00:   byte_v = rdata_i[7:0];
            2'b01:   byte_v = rdata_i[15:8];
            2'b10:   byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_BYTE: result_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
            SZ_HALF: result_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// Load unit: one word read per aligned request, sub-word extract, misaligned loads flagged.
module dm_load_unit
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    dm_load_unit_if.slave     ld
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [31:0]       aligned;

    load_align u_align (
        .rdata_i    (ld.mem_rdata),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        uns_d         = uns_q;
        data_d        = data_q;
        err_d         = err_q;
        ld.req_ready  = 1'b0;
        ld.mem_rd     = 1'b0;
        ld.resp_valid = 1'b0;

        case (state_q)
            StIdle: begin
                ld.req_ready = 1'b1;
                if (ld.req_valid) begin
                    addr_d = ld.req_addr;
                    size_d = ld.req_size;
                    uns_d  = ld.req_unsigned;
                    // Misaligned loads skip the memory entirely and answer with an error.
                    if (is_misaligned(ld.req_addr[1:0], ld.req_size)) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                ld.mem_rd = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                data_d  = aligned;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StResp: begin
                ld.resp_valid = 1'b1;
                if (ld.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ld.mem_addr  = addr_q;
    assign ld.resp_data = data_q;
    assign ld.resp_err  = err_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Self-checking bench for dm_load_unit: directed scenarios plus random loads vs a byte-level model.
module tb_dm_load_unit;

    localparam int unsigned AW = 9;

    logic        clk;
    logic        rst;
    logic [31:0] mem [128];
    int          rd_cnt;
    int          n_tests;
    int          n_fail;

    dm_load_unit_if #(.ADDR_W(AW)) bus ();

    dm_load_unit #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .ld  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rd_cnt = 0;

    // Synchronous-read memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd === 1'b1) begin
            bus.mem_rdata <= mem[bus.mem_addr[8:2]];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Model: a load reads `bytes` little-endian bytes starting at addr; misaligned if addr % bytes.
    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'b11) return 1;
        if (sz == 2'b10) return 2;
        return 4;
    endfunction

    function automatic bit ref_err(input logic [8:0] a, input logic [1:0] sz);
        return (int'(a) % size_bytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] w, input logic [8:0] a,
                                             input logic [1:0] sz, input bit uns);
        int          n;
        logic [31:0] v;
        n = size_bytes(sz);
        if (ref_err(a, sz)) return 32'h0;
        if (n == 4) return w;
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            v = v | (((w >> (8 * ((int'(a) % 4) + i))) & 32'hFF) << (8 * i));
        end
        if (!uns && v[8*n-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic send_accept(input logic [8:0] a, input logic [1:0] sz, input bit uns);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_addr     = a;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        check_eq("req_ready_idle", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic finish_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check_eq("req_ready_after", 32'(bus.req_ready), 32'h1);
    endtask

    task automatic do_load(input logic [8:0] a, input logic [1:0] sz, input bit uns,
                           output logic [31:0] data);
        int  rd0;
        int  lat;
        bit  e;
        rd0 = rd_cnt;
        e   = ref_err(a, sz);
        send_accept(a, sz, uns);
        wait_resp(lat);
        data = bus.resp_data;
        check_eq("latency", 32'(lat), e ? 32'd1 : 32'd3);
        check_eq("resp_data", bus.resp_data, ref_data(mem[a[8:2]], a, sz, uns));
        check_eq("resp_err", 32'(bus.resp_err), 32'(e));
        check_eq("mem_rd_count", 32'(rd_cnt - rd0), e ? 32'd0 : 32'd1);
        finish_resp();
    endtask

    logic [31:0] d;
    logic [31:0] d_hold;
    logic        e_hold;
    int          lat;

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.resp_ready   = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[1] = 32'h8001_F07F;

        #3;
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check_eq("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check_eq("rst_resp_data", bus.resp_data, 32'h0);
        check_eq("rst_resp_err", 32'(bus.resp_err), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_load(9'h007, 2'b11, 1'b0, d); check_eq("tp_lb_007", d, 32'hFFFF_FF80);
        do_load(9'h004, 2'b11, 1'b1, d); check_eq("tp_lbu_004", d, 32'h0000_007F);
        do_load(9'h005, 2'b11, 1'b1, d); check_eq("tp_lbu_005", d, 32'h0000_00F0);
        do_load(9'h005, 2'b11, 1'b0, d); check_eq("tp_lb_005", d, 32'hFFFF_FFF0);
        do_load(9'h006, 2'b10, 1'b0, d); check_eq("tp_lh_006", d, 32'hFFFF_8001);
        do_load(9'h004, 2'b10, 1'b1, d); check_eq("tp_lhu_004", d, 32'h0000_F07F);
        do_load(9'h004, 2'b00, 1'b1, d); check_eq("tp_lw_004", d, 32'h8001_F07F);
        do_load(9'h004, 2'b01, 1'b0, d); check_eq("tp_lw01_004", d, 32'h8001_F07F);
        do_load(9'h005, 2'b10, 1'b0, d); check_eq("tp_lh_005", d, 32'h0);
        do_load(9'h006, 2'b00, 1'b0, d); check_eq("tp_lw_006", d, 32'h0);

        // Response stall with a pending request held on the request side.
        send_accept(9'h005, 2'b11, 1'b1);
        wait_resp(lat);
        check_eq("stall_lat", 32'(lat), 32'd3);
        d_hold           = bus.resp_data;
        e_hold           = bus.resp_err;
        bus.req_valid    = 1'b1;
        bus.req_addr     = 9'h004;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_data", bus.resp_data, d_hold);
            check_eq("stall_err", 32'(bus.resp_err), 32'(e_hold));
            check_eq("stall_valid", 32'(bus.resp_valid), 32'h1);
            check_eq("stall_req_ready", 32'(bus.req_ready), 32'h0);
        end
        check_eq("stall_value", d_hold, 32'h0000_00F0);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check_eq("pend_req_ready", 32'(bus.req_ready), 32'h1);
        check_eq("pend_resp_valid", 32'(bus.resp_valid), 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
        check_eq("pend_lat", 32'(lat), 32'd3);
        check_eq("pend_data", bus.resp_data, 32'h8001_F07F);
        finish_resp();

        // Asynchronous reset in the middle of WAIT.
        send_accept(9'h007, 2'b11, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_req_ready", 32'(bus.req_ready), 32'h1);
        check_eq("arst_mem_rd", 32'(bus.mem_rd), 32'h0);
        check_eq("arst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check_eq("arst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check_eq("arst_resp_data", bus.resp_data, 32'h0);
        check_eq("arst_resp_err", 32'(bus.resp_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("arst_no_resp", 32'(bus.resp_valid), 32'h0);
        end
        do_load(9'h004, 2'b11, 1'b1, d); check_eq("arst_lbu_004", d, 32'h0000_007F);

        // Random loads over random memory contents.
        for (int i = 0; i < 60; i++) begin
            logic [8:0] a;
            logic [1:0] sz;
            bit         uns;
            a   = 9'($urandom_range(0, 511));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            mem[a[8:2]] = $urandom;
            do_load(a, sz, uns, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
